// File: rtl/mips_muldiv_pkg.sv
// ============================================================================
// Module      : mips_muldiv_pkg
// Description : Shared decode constants and state encoding for the MIPS
//               multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_muldiv_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    // Every funct that touches HI/LO and must therefore wait out an operation
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) || (f == FUNCT_MFLO) ||
               (f == FUNCT_MTLO) || (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration: shift-add multiply or
//               shift-subtract restoring divide, selected by mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] work_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] work_out
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    assign w_sum    = {1'b0, acc_in} + (work_in[0] ? {1'b0, operand} : '0);
    assign w_rem_sh = {acc_in, work_in[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow
    assign w_diff   = w_rem_sh - {1'b0, operand};

    always_comb begin
        acc_out  = '0;
        work_out = '0;
        if (mode == MODE_MUL) begin
            acc_out  = w_sum[WIDTH:1];
            work_out = {w_sum[0], work_in[WIDTH-1:1]};
        end else begin
            acc_out  = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            work_out = {work_in[WIDTH-2:0], ~w_diff[WIDTH]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative multiply/divide controller owning HI/LO, with
//               hazard stall generation for the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               op_div_q, op_div_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_rtype;
    logic               w_start_mul;
    logic               w_start_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_work;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_product_fix;

    assign w_rtype     = ex_valid && (ALUop == ALUOP_RTYPE);
    assign w_start_mul = w_rtype && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
    assign w_start_div = w_rtype && ((funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
    assign w_signed    = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign w_rs_abs    = (w_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_abs    = (w_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign w_product     = {acc_q, work_q};
    assign w_product_fix = neg_res_q ? -w_product : w_product;

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .mode     ((state_q == DIV) ? MODE_DIV : MODE_MUL),
        .acc_in   (acc_q),
        .work_in  (work_q),
        .operand  (opnd_q),
        .acc_out  (w_step_acc),
        .work_out (w_step_work)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        op_div_d  = op_div_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (w_start_mul || w_start_div) begin
                    state_d   = w_start_mul ? MUL : DIV;
                    cnt_d     = '0;
                    acc_d     = '0;
                    work_d    = w_rs_abs;
                    opnd_d    = w_rt_abs;
                    neg_res_d = w_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_rem_d = w_signed && rs_val[WIDTH-1];
                    op_div_d  = w_start_div;
                end else if (w_rtype && (funct == FUNCT_MTHI)) begin
                    hi_d = rs_val;
                end else if (w_rtype && (funct == FUNCT_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            MUL, DIV: begin
                acc_d  = w_step_acc;
                work_d = w_step_work;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_div_q) begin
                    lo_d = neg_res_q ? -work_q : work_q;
                    hi_d = neg_rem_q ? -acc_q  : acc_q;
                end else begin
                    hi_d = w_product_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_product_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_div_q  <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            op_div_q  <= op_div_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy && w_rtype && is_hilo_funct(funct);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        hilo_out = '0;
        if (w_rtype && (funct == FUNCT_MFHI)) begin
            hilo_out = hi_q;
        end else if (w_rtype && (funct == FUNCT_MFLO)) begin
            hilo_out = lo_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [1:0]  ALUop = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] hilo_out;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(
        .WIDTH    (32),
        .CNT_W    (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ex_valid (ex_valid),
        .ALUop    (ALUop),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hilo_out (hilo_out),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        ALUop    = 2'b10;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic idle_bus();
        ex_valid = 1'b0;
        ALUop    = 2'b00;
        funct    = 6'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
    endtask

    // Issue one mult/div and return edges from acceptance until busy falls
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        present(f, a, b);
        tick();
        idle_bus();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_move();
        present(FUNCT_MTHI, 32'h11112222, 32'd0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b want 0", stall); end
        tick();
        n_checks++; if (hi !== 32'h11112222) begin n_fail++; $display("FAIL mthi_hi: got %h want 11112222", hi); end
        present(FUNCT_MTLO, 32'h33334444, 32'd0);
        tick();
        n_checks++; if (lo !== 32'h33334444) begin n_fail++; $display("FAIL mtlo_lo: got %h want 33334444", lo); end
        present(FUNCT_MFHI, 32'd0, 32'd0);
        #1;
        n_checks++; if (hilo_out !== 32'h11112222) begin n_fail++; $display("FAIL mfhi_out: got %h want 11112222", hilo_out); end
        present(FUNCT_MFLO, 32'd0, 32'd0);
        #1;
        n_checks++; if (hilo_out !== 32'h33334444) begin n_fail++; $display("FAIL mflo_out: got %h want 33334444", hilo_out); end
        ALUop = 2'b00;
        #1;
        n_checks++; if (hilo_out !== 32'd0) begin n_fail++; $display("FAIL non_rtype_out: got %h want 0", hilo_out); end
        idle_bus();
        tick();
    endtask

    task automatic test_multu();
        int cyc;
        run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", done); end
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signed();
        int cyc;
        run_op(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, cyc);
        present(FUNCT_MFHI, 32'd0, 32'd0);
        #1;
        n_checks++; if (hilo_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_mfhi: got %h want ffffffff", hilo_out); end
        present(FUNCT_MFLO, 32'd0, 32'd0);
        #1;
        n_checks++; if (hilo_out !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_mflo: got %h want fffffff1", hilo_out); end
        idle_bus();
        tick();
        run_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, cyc);
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        tick();
    endtask

    task automatic test_div_corners();
        int cyc;
        run_op(FUNCT_DIVU, 32'h00001234, 32'd0, cyc);
        n_checks++; if (hi !== 32'h00001234) begin n_fail++; $display("FAIL divu_zero_hi: got %h want 00001234", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo); end
        tick();
        run_op(FUNCT_DIV, 32'hFFFFFFF8, 32'd0, cyc);
        n_checks++; if (hi !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL div_zero_neg_hi: got %h want fffffff8", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL div_zero_neg_lo: got %h want 00000001", lo); end
        tick();
        run_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        tick();
    endtask

    task automatic test_stall_mflo();
        int scnt;
        int bad;
        present(FUNCT_MULT, 32'd6, 32'd7);
        tick();
        idle_bus();
        tick();
        present(FUNCT_MFLO, 32'd0, 32'd0);
        #1;
        scnt = 0;
        bad  = 0;
        while (busy === 1'b1 && scnt < 100) begin
            if (stall !== 1'b1) bad++;
            tick();
            scnt++;
        end
        n_checks++; if (scnt !== 32) begin n_fail++; $display("FAIL stall_cycles: got %0d want 32", scnt); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_held: got %0d low cycles want 0", bad); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", stall); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done); end
        n_checks++; if (hilo_out !== 32'd42) begin n_fail++; $display("FAIL stall_mflo_new: got %h want 0000002a", hilo_out); end
        tick();
        idle_bus();
    endtask

    task automatic test_reset_abort();
        int seen;
        present(FUNCT_MULTU, 32'h00010000, 32'h00030000);
        tick();
        idle_bus();
        repeat (9) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", lo); end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        present(FUNCT_MTHI, 32'h0000ABCD, 32'd0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_mthi_stall: got %b want 0", stall); end
        tick();
        n_checks++; if (hi !== 32'h0000ABCD) begin n_fail++; $display("FAIL abort_mthi_hi: got %h want 0000abcd", hi); end
        idle_bus();
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int cyc2;
        int st;
        present(FUNCT_MULT, 32'h00010000, 32'h00010000);
        tick();
        present(FUNCT_DIV, 32'd100, 32'd7);
        cyc = 0;
        st  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall === 1'b1) st++;
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_mult_done_at: got %0d want 33", cyc); end
        n_checks++; if (st !== 33) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 33", st); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got %b want 0", stall); end
        n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL b2b_mult_result: got %h_%h want 00000001_00000000", hi, lo); end
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_div_accept: got %b want 1", busy); end
        idle_bus();
        cyc2 = 1;
        while (done !== 1'b1 && cyc2 < 100) begin
            tick();
            cyc2++;
        end
        n_checks++; if (cyc2 !== 34) begin n_fail++; $display("FAIL b2b_div_done_at: got %0d want 34", cyc2); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_div_hi: got %h want 00000002", hi); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_div_lo: got %h want 0000000e", lo); end
        tick();
    endtask

    initial begin
        test_reset();
        test_move();
        test_multu();
        test_signed();
        test_div_corners();
        test_stall_mflo();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
